// File: rtl/led_pwm_fader.sv
// PWM LED driver with a linear fade-out "comet tail" on channels that switch off.
// Define LED_FADE_TRAIL_EN for the decaying tail; otherwise off channels go dark at the next frame.
module led_pwm_fader #(
    parameter int CHANNELS    = 6,
    parameter int PWM_DIV     = 4,
    parameter int FADE_FRAMES = 400,
    parameter int FADE_STEP   = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [CHANNELS-1:0] pat_in,
    input  logic [7:0]          bright,
    output logic [CHANNELS-1:0] led_out,
    output logic                frame_start
);

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PWM_DIV - 1);

    if (PWM_DIV < 1 || FADE_FRAMES < 1 || FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_params
        $error("led_pwm_fader: parameter out of range");
    end

    logic [CHANNELS-1:0] pat_q;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic [7:0]          level_q [CHANNELS];
    logic [7:0]          level_d [CHANNELS];
    logic [CHANNELS-1:0] led_q, led_d;
    logic                frame_start_q;
    logic                pwm_tick;
    logic                frame_end;

    assign pwm_tick  = (div_cnt_q == DIV_MAX);
    assign frame_end = pwm_tick && (pwm_cnt_q == 8'd255);

    always_comb begin
        div_cnt_d = pwm_tick ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d = pwm_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

`ifdef LED_FADE_TRAIL_EN
    localparam int FR_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_MAX = FR_W'(FADE_FRAMES - 1);
    localparam logic [7:0] STEP8 = 8'(FADE_STEP);

    logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            fade_tick;

    assign fade_tick = frame_end && (frame_cnt_q == FR_MAX);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_end) begin
            frame_cnt_d = (frame_cnt_q == FR_MAX) ? '0 : frame_cnt_q + FR_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    // Levels change only at frame boundaries so a frame never mixes two duty cycles.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            level_d[i] = level_q[i];
            if (frame_end) begin
                if (!pat_q[i]) begin
                    level_d[i] = bright;
`ifdef LED_FADE_TRAIL_EN
                end else if (fade_tick) begin
                    level_d[i] = (level_q[i] > STEP8) ? level_q[i] - STEP8 : 8'd0;
`else
                end else begin
                    level_d[i] = 8'd0;
`endif
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            led_d[i] = ~(pwm_cnt_q < level_q[i]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pat_q         <= '1;
            div_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            led_q         <= '1;
            frame_start_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= 8'd0;
            end
        end else begin
            pat_q         <= pat_in;
            div_cnt_q     <= div_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_q         <= led_d;
            frame_start_q <= frame_end;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out     = led_q;
    assign frame_start = frame_start_q;

endmodule
